// File: rtl/dequantizer_array.sv
// N-lane level-to-FP32 dequantizer: 3-stage lock-step pipeline, power-of-two scale, FP32 pass-through lanes.
// Optional macro DEQ_ROUND_EN selects round-to-nearest-even instead of truncation for >24-bit magnitudes.
module dequantizer_array #(
    parameter int NUM_LANES = 2,
    parameter int LEVEL_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [32*NUM_LANES-1:0]   level,
    input  logic [NUM_LANES-1:0]      is_weight,
    input  logic [7:0]                step_exp,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [32*NUM_LANES-1:0]   weight_fp,
    output logic [NUM_LANES-1:0]      sat_flag
);

    localparam int SHIFT = 32 - LEVEL_W;

    logic adv;

    logic                         v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
    logic [7:0]                   step1_d, step1_q, step2_d, step2_q;
    logic [NUM_LANES-1:0]         wt1_d, wt1_q, wt2_d, wt2_q;
    logic [NUM_LANES-1:0]         sign1_d, sign1_q, sign2_d, sign2_q;
    logic [NUM_LANES-1:0]         zero2_d, zero2_q;
    logic [NUM_LANES-1:0][31:0]   data1_d, data1_q, raw2_d, raw2_q;
    logic [NUM_LANES-1:0][22:0]   mant2_d, mant2_q;
    logic [NUM_LANES-1:0][5:0]    exp2_d, exp2_q;
    logic [NUM_LANES-1:0][31:0]   fp3_d, fp3_q;
    logic [NUM_LANES-1:0]         sat3_d, sat3_q;

    // Every stage moves together whenever the output register is free or being drained.
    assign adv       = out_ready | ~v3_q;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign weight_fp = fp3_q;
    assign sat_flag  = sat3_q;

    // S1: sign-extend the level slot and split it into sign and magnitude.
    always_comb begin : s1_comb
        logic [31:0]        slot;
        logic signed [31:0] sext;
        // NOTE: every always_comb target gets a default up front so no path leaves it unassigned (no latch).
        v1_d    = in_valid;
        step1_d = step_exp;
        wt1_d   = is_weight;
        sign1_d = '0;
        data1_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            slot = level[32*i +: 32];
            sext = slot << SHIFT;
            sext = sext >>> SHIFT;
            if (is_weight[i]) begin
                sign1_d[i] = sext[31];
                data1_d[i] = sext[31] ? -sext : sext;
            end else begin
                data1_d[i] = slot;
            end
        end
    end

    // S2: leading-one detect and normalise; the hidden one is dropped from the mantissa.
    always_comb begin : s2_comb
        logic [31:0] mag;
        logic [4:0]  pos;
`ifdef DEQ_ROUND_EN
        logic [30:0] norm;
        logic        round_up;
        logic [23:0] rounded;
`endif
        v2_d    = v1_q;
        step2_d = step1_q;
        wt2_d   = wt1_q;
        sign2_d = sign1_q;
        raw2_d  = data1_q;
        zero2_d = '0;
        mant2_d = '0;
        exp2_d  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            mag = data1_q[i];
            pos = '0;
            for (int b = 0; b < 32; b++) begin
                if (mag[b]) pos = 5'(b);
            end
            zero2_d[i] = (mag == 32'd0);
`ifdef DEQ_ROUND_EN
            norm     = 31'(mag << (5'd31 - pos));
            round_up = norm[7] & (norm[8] | (norm[6:0] != 7'd0));
            rounded  = {1'b0, norm[30:8]} + {23'd0, round_up};
            // A carry out of the mantissa leaves it all zero and bumps the exponent.
            mant2_d[i] = rounded[22:0];
            exp2_d[i]  = {1'b0, pos} + {5'd0, rounded[23]};
`else
            mant2_d[i] = 23'((mag << (5'd31 - pos)) >> 8);
            exp2_d[i]  = {1'b0, pos};
`endif
        end
    end

    // S3: biased exponent with the shared scale, then saturate, flush or pack.
    always_comb begin : s3_comb
        logic signed [9:0] e_big;
        v3_d   = v2_q;
        fp3_d  = '0;
        sat3_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            e_big = 10'sd127 + $signed({4'd0, exp2_q[i]})
                  + $signed({{2{step2_q[7]}}, step2_q});
            if (!wt2_q[i]) begin
                fp3_d[i] = raw2_q[i];
            end else if (zero2_q[i]) begin
                fp3_d[i] = '0;
            end else if (e_big >= 10'sd255) begin
                fp3_d[i]  = {sign2_q[i], 31'h7F7F_FFFF};
                sat3_d[i] = 1'b1;
            end else if (e_big <= 10'sd0) begin
                fp3_d[i]  = {sign2_q[i], 31'd0};
                sat3_d[i] = 1'b1;
            end else begin
                fp3_d[i] = {sign2_q[i], e_big[7:0], mant2_q[i]};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            step1_q <= '0;
            step2_q <= '0;
            wt1_q   <= '0;
            wt2_q   <= '0;
            sign1_q <= '0;
            sign2_q <= '0;
            zero2_q <= '0;
            data1_q <= '0;
            raw2_q  <= '0;
            mant2_q <= '0;
            exp2_q  <= '0;
            fp3_q   <= '0;
            sat3_q  <= '0;
        end else if (adv) begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            step1_q <= step1_d;
            step2_q <= step2_d;
            wt1_q   <= wt1_d;
            wt2_q   <= wt2_d;
            sign1_q <= sign1_d;
            sign2_q <= sign2_d;
            zero2_q <= zero2_d;
            data1_q <= data1_d;
            raw2_q  <= raw2_d;
            mant2_q <= mant2_d;
            exp2_q  <= exp2_d;
            fp3_q   <= fp3_d;
            sat3_q  <= sat3_d;
        end
    end

endmodule

// File: tb/tb_dequantizer_array.sv
// Directed bench for dequantizer_array (2 lanes, 32-bit levels): vector table, backpressure and mid-stream reset.
module tb_dequantizer_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] level;
    logic [1:0]  is_weight;
    logic [7:0]  step_exp;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] weight_fp;
    logic [1:0]  sat_flag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] l0;
        logic [31:0] l1;
        logic [1:0]  isw;
        logic [7:0]  step;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  sat;
    } vec_t;

    vec_t vecs[10];

    dequantizer_array #(.NUM_LANES(2), .LEVEL_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .level     (level),
        .is_weight (is_weight),
        .step_exp  (step_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .weight_fp (weight_fp),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; presents one beat and checks the 3-cycle latency and the result.
    task automatic send_and_check(input vec_t v, input string tag);
        in_valid  = 1'b1;
        level     = {v.l1, v.l0};
        is_weight = v.isw;
        step_exp  = v.step;
        out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        level     = 64'hDEAD_BEEF_DEAD_BEEF;
        step_exp  = 8'h55;
        check({tag, " lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, " lat2"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, " lat3"}, 32'(out_valid), 32'd1);
        check({tag, " lane0"}, weight_fp[31:0], v.e0);
        check({tag, " lane1"}, weight_fp[63:32], v.e1);
        check({tag, " sat"}, 32'(sat_flag), 32'(v.sat));
    endtask

    logic [31:0] fp_tab[6];

    initial begin
        int sent, got, cyc, stall_left;
        vec_t v;

        vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFD, 2'b11, 8'h00, 32'h3F80_0000, 32'hC040_0000, 2'b00};
        vecs[1] = '{32'h0000_0001, 32'hFFFF_FFFD, 2'b11, 8'hFF, 32'h3F00_0000, 32'hBFC0_0000, 2'b00};
        vecs[2] = '{32'h0000_0000, 32'h4049_0FDB, 2'b01, 8'h05, 32'h0000_0000, 32'h4049_0FDB, 2'b00};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b11, 8'h7F, 32'h7F7F_FFFF, 32'h7F00_0000, 2'b01};
        vecs[4] = '{32'h0000_0001, 32'hFFFF_FFFF, 2'b11, 8'h80, 32'h0000_0000, 32'h8000_0000, 2'b11};
`ifdef DEQ_ROUND_EN
        vecs[5] = '{32'h0100_0003, 32'h8000_0000, 2'b11, 8'h00, 32'h4B80_0002, 32'hCF00_0000, 2'b00};
        vecs[8] = '{32'h01FF_FFFF, 32'hFFFF_FFFF, 2'b01, 8'h00, 32'h4C00_0000, 32'hFFFF_FFFF, 2'b00};
`else
        vecs[5] = '{32'h0100_0003, 32'h8000_0000, 2'b11, 8'h00, 32'h4B80_0001, 32'hCF00_0000, 2'b00};
        vecs[8] = '{32'h01FF_FFFF, 32'hFFFF_FFFF, 2'b01, 8'h00, 32'h4BFF_FFFF, 32'hFFFF_FFFF, 2'b00};
`endif
        vecs[6] = '{32'h0000_0001, 32'h0000_0002, 2'b11, 8'h82, 32'h0080_0000, 32'h0100_0000, 2'b00};
        vecs[7] = '{32'h0000_0002, 32'hFFFF_FFFE, 2'b11, 8'h7F, 32'h7F7F_FFFF, 32'hFF7F_FFFF, 2'b11};
        vecs[9] = '{32'h0000_0000, 32'h0000_0005, 2'b01, 8'h7F, 32'h0000_0000, 32'h0000_0005, 2'b00};

        fp_tab = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                   32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        level     = '0;
        is_weight = 2'b11;
        step_exp  = '0;
        #2;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset weight_fp lo", weight_fp[31:0], 32'd0);
        check("reset weight_fp hi", weight_fp[63:32], 32'd0);
        check("reset sat_flag", 32'(sat_flag), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;

        for (int k = 0; k < 10; k++) begin
            send_and_check(vecs[k], $sformatf("vec%0d", k));
        end
        @(posedge clk); #1;
        check("drain out_valid", 32'(out_valid), 32'd0);

        // Backpressure: six beats, output stalled for 5 cycles once the first result shows up.
        sent = 0; got = 0; cyc = 0; stall_left = -1;
        is_weight = 2'b11;
        step_exp  = 8'h00;
        while (got < 6 && cyc < 200) begin
            if (stall_left < 0 && out_valid) stall_left = 5;
            out_ready = !(stall_left > 0);
            in_valid  = (sent < 6);
            level     = {32'(sent + 1), 32'(sent + 1)};
            #1;
            if (stall_left > 0) begin
                check("stall in_ready", 32'(in_ready), 32'd0);
                check("stall out_valid", 32'(out_valid), 32'd1);
                check("stall hold", weight_fp[31:0], 32'h3F80_0000);
                stall_left--;
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp lane0 beat%0d", got), weight_fp[31:0], fp_tab[got]);
                check($sformatf("bp lane1 beat%0d", got), weight_fp[63:32], fp_tab[got]);
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("bp beats received", 32'(got), 32'd6);
        check("bp no duplicate", 32'(out_valid), 32'd0);

        // Reset with three beats in flight.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            level    = {32'(7 + k), 32'(7 + k)};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst weight_fp lo", weight_fp[31:0], 32'd0);
        check("midrst weight_fp hi", weight_fp[63:32], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        v = '{32'h0000_0002, 32'h0000_0002, 2'b11, 8'h00, 32'h4000_0000, 32'h4000_0000, 2'b00};
        send_and_check(v, "post-reset");
        @(posedge clk); #1;
        check("post-reset drain", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
